seq_mul_responder: RTL and testbench
====================================

Name: seq_mul_responder

Overview:
- Sequential unsigned 64x64 multiplier that acts as the responder side of the op_start/op_clear/op_done handshake used by the factorial controller.
- The controller registers the operands and strobes op_start. This block iterates shift-add, then holds a 128-bit product and op_done until op_clear.
- It sits directly under the factorial controller and is the only arithmetic engine it drives.

Parameters:
- WIDTH, 64, operand width in bits; result is 2*WIDTH.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- multiplier  input  WIDTH  operand A; sampled only on accepted op_start.
- multiplicand  input  WIDTH  operand B; sampled only on accepted op_start.
- op_start  input  1  level request to begin; accepted only in IDLE.
- op_clear  input  1  synchronous abort/clear; highest priority after reset.
- op_done  output  1  registered; high while the product is valid.
- result  output  2*WIDTH  registered product/accumulator.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - reset_n=0 forces state=IDLE, result=0, op_done=0, counter=0 and internal operand registers to 0, immediately and without waiting for clk.
  - Reset mid-EXEC discards the operation.
- States: IDLE, EXEC, DONE; 2-bit registered encoding.
- Priority each edge: op_clear, then op_start, then iteration.
- op_clear=1 in any state: next state IDLE, result=0, op_done=0, counter=0. op_start is ignored on that same edge.
- IDLE:
  - With op_start=1 and op_clear=0: latch multiplicand into a 2*WIDTH shift register (upper half zero) and multiplier into a WIDTH shift register.
  - On the same edge: result=0, counter=0, go to EXEC.
- EXEC, per edge:
  - If multiplier LSB=1, result += shifted multiplicand; the sum is modulo 2^(2*WIDTH) and never overflows for unsigned operands.
  - Shift the multiplicand left 1 and the multiplier right 1; counter+1.
  - On the edge where the counter reaches WIDTH-1, perform the last add, assert op_done and go to DONE.
  - Latency: accept edge k; op_done visible after edge k+WIDTH (64 edges).
- DONE: result and op_done are held. op_start is ignored, including when it is held high. Exit only via op_clear or reset.
- op_start in EXEC is ignored. Operand input changes after acceptance have no effect.
- op_done=0 in IDLE and EXEC. result is a partial sum during EXEC and must not be consumed.
- Zero operands run the full iteration count; there is no early exit.

Optional Feature:
- Macro SEQ_MUL_RADIX4_EN.
- Defined: two multiplier bits are consumed per edge. The add term is 0, 1x, 2x or 3x the multiplicand; 3x is precomputed at accept. Shifts are 2 and WIDTH must be even.
  - Latency is WIDTH/2 edges (32); op_done asserts after edge k+32.
- Undefined: radix-2 behaviour as above.
- Results are bit-identical in both builds.

Decomposition:
- Shared package holds:
  - Constants MUL_IDLE=2'b00, MUL_EXEC=2'b01, MUL_DONE=2'b10.
  - WIDTH default 64.
  - Iteration-count constant (WIDTH or WIDTH/2 under the macro).
- One sub-module: mul_iter_cnt, a CNT_W-bit counter with async active-low reset, synchronous clear and enable, and a terminal-count output. Terminal count is WIDTH-1, or WIDTH/2-1 under the macro.
- Datapath and FSM stay in the top.

Test Plan:
- multiplier=5, multiplicand=4, op_start for 1 cycle:
  - op_done rises exactly 64 edges after acceptance (32 with SEQ_MUL_RADIX4_EN).
  - result=128'h14; holds until op_clear, after which result=0 and op_done=0 on the next edge.
- Both operands 64'hFFFF_FFFF_FFFF_FFFF -> result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- multiplier=0, multiplicand=64'h1234 -> op_done after full latency, result=0. Swapped operands -> same result.
- op_clear at iteration 10 of an EXEC:
  - Next edge: IDLE, result=0, op_done=0.
  - A new op_start 3*5 then gives result=15.
- op_start held high through EXEC/DONE and operands changed after acceptance (start 7*6, then inputs 9*9) -> single operation, result=42, no restart while in DONE.
- reset_n pulsed low asynchronously between edges mid-EXEC:
  - result and op_done go to 0 immediately.
  - After release, idle until op_start; 2*3 then gives result=6.

Source files
------------

// File: rtl/seq_mul_responder_pkg.sv
// Shared definitions for the sequential multiplier responder.
// Optional build macro: SEQ_MUL_RADIX4_EN (two multiplier bits per iteration).
package seq_mul_responder_pkg;

  localparam int unsigned MUL_WIDTH = 64;
  localparam int unsigned MUL_CNT_W = 7;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_EXEC = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // Iterations needed to consume all multiplier bits.
  function automatic int unsigned iter_count(input int unsigned width);
`ifdef SEQ_MUL_RADIX4_EN
    return width / 2;
`else
    return width;
`endif
  endfunction

  localparam int unsigned MUL_ITERS = iter_count(MUL_WIDTH);

endpackage

// File: rtl/seq_mul_responder_if.sv
// op_start/op_clear/op_done handshake between the controller and the multiplier.
interface seq_mul_responder_if #(
  parameter int unsigned WIDTH = 64
);
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   multiplicand;
  logic               op_start;
  logic               op_clear;
  logic               op_done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output multiplier, multiplicand, op_start, op_clear,
    input  op_done, result
  );

  modport slave (
    input  multiplier, multiplicand, op_start, op_clear,
    output op_done, result
  );
endinterface

// File: rtl/mul_iter_cnt.sv
// Iteration counter with synchronous clear, enable and terminal-count flag.
module mul_iter_cnt #(
  parameter int unsigned CNT_W = 7,
  parameter int unsigned TERM  = 63
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TERM);

  logic [CNT_W-1:0] cnt_q;

  // Count up while enabled; clear wins over enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TermCnt);

endmodule

// File: rtl/seq_mul_responder.sv
// Sequential unsigned shift-add multiplier, responder side of op_start/op_clear/op_done.
// Optional build macro: SEQ_MUL_RADIX4_EN (radix-4, half the iterations, same results).
module seq_mul_responder
  import seq_mul_responder_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  // Must satisfy 2**CNT_W > WIDTH.
  parameter int unsigned CNT_W = MUL_CNT_W
) (
  input logic                 clk,
  input logic                 reset_n,
  seq_mul_responder_if.slave  bus
);

  localparam int unsigned Iters = iter_count(WIDTH);
  localparam int unsigned RW    = 2 * WIDTH;

  mul_state_e       state_q;
  logic [RW-1:0]    result_q;
  logic             done_q;
  logic [RW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [RW-1:0]    add_term;
  logic             accept;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt;

`ifdef SEQ_MUL_RADIX4_EN
  logic [RW-1:0]    mcand3_q;
  logic [RW-1:0]    mcand_ext;
  assign mcand_ext = {{WIDTH{1'b0}}, bus.multiplicand};
`endif

  assign accept = (state_q == MUL_IDLE) && bus.op_start && !bus.op_clear;

  mul_iter_cnt #(
    .CNT_W (CNT_W),
    .TERM  (Iters - 1)
  ) u_iter_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (bus.op_clear || accept),
    .en_i    (state_q == MUL_EXEC),
    .cnt_o   (cnt),
    .tc_o    (cnt_tc)
  );

  // Partial product selected by the low multiplier bit(s).
  always_comb begin
    add_term = '0;
`ifdef SEQ_MUL_RADIX4_EN
    unique case (mplier_q[1:0])
      2'b00:   add_term = '0;
      2'b01:   add_term = mcand_q;
      2'b10:   add_term = mcand_q << 1;
      default: add_term = mcand3_q;
    endcase
`else
    if (mplier_q[0]) add_term = mcand_q;
`endif
  end

  // FSM and datapath: clear beats start, start beats iteration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= MUL_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
`ifdef SEQ_MUL_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else if (bus.op_clear) begin
      state_q  <= MUL_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        MUL_IDLE: begin
          if (bus.op_start) begin
            mcand_q  <= {{WIDTH{1'b0}}, bus.multiplicand};
            mplier_q <= bus.multiplier;
`ifdef SEQ_MUL_RADIX4_EN
            mcand3_q <= mcand_ext + (mcand_ext << 1);
`endif
            result_q <= '0;
            state_q  <= MUL_EXEC;
          end
        end
        MUL_EXEC: begin
          // Sum fits in 2*WIDTH bits for unsigned operands.
          result_q <= result_q + add_term;
`ifdef SEQ_MUL_RADIX4_EN
          mcand_q  <= mcand_q << 2;
          mcand3_q <= mcand3_q << 2;
          mplier_q <= mplier_q >> 2;
`else
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
`endif
          if (cnt_tc) begin
            done_q  <= 1'b1;
            state_q <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          // Hold product until op_clear or reset.
        end
        default: begin
          state_q <= MUL_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_done = done_q;
  assign bus.result  = result_q;

endmodule

// File: tb/tb_seq_mul_responder.sv
// Self-checking bench for seq_mul_responder: vector table plus multi-cycle corner sequences.
module tb_seq_mul_responder;

`ifdef SEQ_MUL_RADIX4_EN
  localparam int Lat = 32;
`else
  localparam int Lat = 64;
`endif

  logic clk = 1'b0;
  logic reset_n;

  seq_mul_responder_if #(.WIDTH(64)) bus ();

  seq_mul_responder #(
    .WIDTH (64),
    .CNT_W (7)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] exp;
  } vec_t;

  vec_t          vecs[8];
  logic [127:0]  sb_q[$];
  int            n_total = 0;
  int            n_pass  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive operands at the falling edge; accepted on the following rising edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input bit hold);
    @(negedge clk);
    bus.multiplier   = a;
    bus.multiplicand = b;
    bus.op_start     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.op_start = 1'b0;
  endtask

  // Count edges after acceptance until op_done; compare latency and popped product.
  task automatic wait_done(input string name);
    int n;
    logic [127:0] exp;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.op_done && n < Lat + 20);
    check({name, " latency"}, 128'(n), 128'(Lat));
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 128'(1), 128'(0));
    end else begin
      exp = sb_q.pop_front();
      check({name, " result"}, bus.result, exp);
    end
  endtask

  task automatic do_clear(input string name);
    @(negedge clk);
    bus.op_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.op_clear = 1'b0;
    check({name, " clr result"}, bus.result, 128'h0);
    check({name, " clr done"}, 128'(bus.op_done), 128'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] ra, rb;
    vecs[0] = '{"5x4",     64'd5, 64'd4, 128'h14};
    vecs[1] = '{"max",     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    vecs[2] = '{"0x1234",  64'd0, 64'h1234, 128'h0};
    vecs[3] = '{"1234x0",  64'h1234, 64'd0, 128'h0};
    vecs[4] = '{"1xmax",   64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{"pow2",    64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000};
    for (int i = 6; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      vecs[i] = '{$sformatf("rnd%0d", i), ra, rb, {64'h0, ra} * {64'h0, rb}};
    end

    reset_n          = 1'b0;
    bus.op_start     = 1'b0;
    bus.op_clear     = 1'b0;
    bus.multiplier   = '0;
    bus.multiplicand = '0;
    #23;
    check("reset result", bus.result, 128'h0);
    check("reset done", 128'(bus.op_done), 128'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Vector table: run, check latency/result, hold in DONE, clear.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, 1'b0);
      sb_q.push_back(vecs[i].exp);
      wait_done(vecs[i].name);
      repeat (3) @(posedge clk);
      #1;
      check({vecs[i].name, " held"}, bus.result, vecs[i].exp);
      do_clear(vecs[i].name);
    end

    // Abort at iteration 10, then a fresh operation.
    start_op(64'd7, 64'd7, 1'b0);
    repeat (10) @(posedge clk);
    do_clear("abort");
    repeat (Lat + 5) @(posedge clk);
    #1;
    check("abort stays idle", 128'(bus.op_done), 128'h0);
    start_op(64'd3, 64'd5, 1'b0);
    sb_q.push_back(128'd15);
    wait_done("after abort");
    do_clear("after abort");

    // op_start held high, operands changed after acceptance.
    start_op(64'd7, 64'd6, 1'b1);
    bus.multiplier   = 64'd9;
    bus.multiplicand = 64'd9;
    sb_q.push_back(128'd42);
    wait_done("held start");
    repeat (Lat + 5) @(posedge clk);
    #1;
    check("held start no restart result", bus.result, 128'd42);
    check("held start no restart done", 128'(bus.op_done), 128'h1);
    bus.op_start = 1'b0;
    do_clear("held start");

    // Asynchronous reset between edges mid-EXEC.
    start_op(64'hFFFF, 64'h1357, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async rst result", bus.result, 128'h0);
    check("async rst done", 128'(bus.op_done), 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (Lat + 5) @(posedge clk);
    #1;
    check("post rst idle", 128'(bus.op_done), 128'h0);
    start_op(64'd2, 64'd3, 1'b0);
    sb_q.push_back(128'd6);
    wait_done("after rst");

    // Asynchronous reset while holding a product in DONE.
    #3;
    reset_n = 1'b0;
    #1;
    check("rst in done result", bus.result, 128'h0);
    check("rst in done done", 128'(bus.op_done), 128'h0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
